// File: rtl/mac_loop_ctrl.sv
// Nested-loop offset generator: walks NB_LOOPS counters and emits NB_STREAMS offsets per beat.
// Optional stall counter on stall_cnt_o is built only when MAC_LOOP_CTRL_PERF_CNT_EN is defined.
module mac_loop_ctrl #(
    parameter int unsigned NB_LOOPS   = 3,
    parameter int unsigned NB_STREAMS = 3,
    parameter int unsigned CNT_WIDTH  = 16,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                                             clk_i,
    input  logic                                             rst_i,
    input  logic                                             clear_i,
    input  logic                                             start_i,
    input  logic [NB_LOOPS-1:0][CNT_WIDTH-1:0]               cfg_nb_iter_i,
    input  logic [NB_LOOPS-1:0][NB_STREAMS-1:0][ADDR_WIDTH-1:0] cfg_stride_i,
    input  logic [NB_STREAMS-1:0][ADDR_WIDTH-1:0]            cfg_base_i,
    output logic                                             valid_o,
    input  logic                                             ready_i,
    output logic [NB_STREAMS-1:0][ADDR_WIDTH-1:0]            offset_o,
    output logic [NB_LOOPS-1:0][CNT_WIDTH-1:0]               idx_o,
    output logic [NB_LOOPS-1:0]                              last_o,
    output logic                                             busy_o,
    output logic                                             done_o
`ifdef MAC_LOOP_CTRL_PERF_CNT_EN
    ,
    output logic [31:0]                                      stall_cnt_o
`endif
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e                                        state_q;
    logic                                          done_q;
    logic [NB_LOOPS-1:0][CNT_WIDTH-1:0]            nb_iter_q;
    logic [NB_LOOPS-1:0][NB_STREAMS-1:0][ADDR_WIDTH-1:0] stride_q;
    logic [NB_STREAMS-1:0][ADDR_WIDTH-1:0]         offset_q, offset_d;
    logic [NB_LOOPS-1:0][CNT_WIDTH-1:0]            idx_q, idx_d;
    logic [NB_STREAMS-1:0][ADDR_WIDTH-1:0]         jump;
    logic                                          accept;

    assign valid_o  = (state_q == StRun);
    assign busy_o   = (state_q == StRun);
    assign done_o   = done_q;
    assign offset_o = offset_q;
    assign idx_o    = idx_q;
    assign accept   = valid_o & ready_i;

    // Ripple-carry over loops: the first loop not at its limit advances and selects its stride.
    always_comb begin
        logic all_eq;
        logic carry;
        all_eq = 1'b1;
        carry  = 1'b1;
        idx_d  = idx_q;
        jump   = '0;
        last_o = '0;
        for (int l = 0; l < NB_LOOPS; l++) begin
            all_eq    = all_eq & (idx_q[l] == nb_iter_q[l]);
            last_o[l] = valid_o & all_eq;
            if (carry) begin
                if (idx_q[l] == nb_iter_q[l]) begin
                    idx_d[l] = '0;
                end else begin
                    idx_d[l] = idx_q[l] + CNT_WIDTH'(1);
                    jump     = stride_q[l];
                    carry    = 1'b0;
                end
            end
        end
        for (int s = 0; s < NB_STREAMS; s++) begin
            offset_d[s] = offset_q[s] + jump[s];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            state_q   <= StIdle;
            done_q    <= 1'b0;
            nb_iter_q <= '0;
            stride_q  <= '0;
            offset_q  <= '0;
            idx_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start_i) begin
                        state_q   <= StRun;
                        nb_iter_q <= cfg_nb_iter_i;
                        stride_q  <= cfg_stride_i;
                        offset_q  <= cfg_base_i;
                        idx_q     <= '0;
                    end
                end
                StRun: begin
                    if (accept) begin
                        idx_q <= idx_d;
                        if (last_o[NB_LOOPS-1]) begin
                            state_q <= StIdle;
                            done_q  <= 1'b1;
                        end else begin
                            offset_q <= offset_d;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef MAC_LOOP_CTRL_PERF_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            stall_cnt_q <= '0;
        end else if (state_q == StIdle && start_i) begin
            stall_cnt_q <= '0;
        end else if (valid_o && !ready_i && stall_cnt_q != '1) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mac_loop_ctrl.sv
// Directed bench for mac_loop_ctrl with two loops and two streams.
module tb_mac_loop_ctrl;

    logic                        clk = 1'b0;
    logic                        rst_i, clear_i, start_i, ready_i;
    logic [1:0][15:0]            cfg_nb_iter;
    logic [1:0][1:0][31:0]       cfg_stride;
    logic [1:0][31:0]            cfg_base;
    logic                        valid_o, busy_o, done_o;
    logic [1:0][31:0]            offset_o;
    logic [1:0][15:0]            idx_o;
    logic [1:0]                  last_o;
`ifdef MAC_LOOP_CTRL_PERF_CNT_EN
    logic [31:0]                 stall_cnt_o;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mac_loop_ctrl #(
        .NB_LOOPS   (2),
        .NB_STREAMS (2),
        .CNT_WIDTH  (16),
        .ADDR_WIDTH (32)
    ) u_dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .clear_i       (clear_i),
        .start_i       (start_i),
        .cfg_nb_iter_i (cfg_nb_iter),
        .cfg_stride_i  (cfg_stride),
        .cfg_base_i    (cfg_base),
        .valid_o       (valid_o),
        .ready_i       (ready_i),
        .offset_o      (offset_o),
        .idx_o         (idx_o),
        .last_o        (last_o),
        .busy_o        (busy_o),
        .done_o        (done_o)
`ifdef MAC_LOOP_CTRL_PERF_CNT_EN
        ,
        .stall_cnt_o   (stall_cnt_o)
`endif
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Launches a job from a negedge; returns at the negedge where the first beat is visible.
    task automatic start_job(input logic [15:0] nb0, input logic [15:0] nb1,
                             input logic [31:0] s00, input logic [31:0] s01,
                             input logic [31:0] s10, input logic [31:0] s11,
                             input logic [31:0] b0, input logic [31:0] b1);
        cfg_nb_iter   = {nb1, nb0};
        cfg_stride[0] = {s01, s00};
        cfg_stride[1] = {s11, s10};
        cfg_base      = {b1, b0};
        start_i       = 1'b1;
        @(negedge clk);
        start_i       = 1'b0;
    endtask

    // Checks the beat on show, then advances one cycle (accepted if ready_i is high).
    task automatic expect_beat(input string tag, input logic [31:0] o0, input logic [31:0] o1,
                               input logic [15:0] i0, input logic [15:0] i1,
                               input logic [1:0] lst);
        check_eq({tag, " valid"}, 64'(valid_o), 64'd1);
        check_eq({tag, " offset"}, 64'(offset_o), {o1, o0});
        check_eq({tag, " idx"}, 64'(idx_o), 64'({i1, i0}));
        check_eq({tag, " last"}, 64'(last_o), 64'(lst));
        @(negedge clk);
    endtask

    task automatic expect_done(input string tag);
        check_eq({tag, " done valid"}, 64'(valid_o), 64'd0);
        check_eq({tag, " done busy"}, 64'(busy_o), 64'd0);
        check_eq({tag, " done pulse"}, 64'(done_o), 64'd1);
        @(negedge clk);
        check_eq({tag, " done width"}, 64'(done_o), 64'd0);
    endtask

    task automatic scen2_beats(input string tag);
        expect_beat({tag, " b1"}, 32'h00, 32'h00, 16'd0, 16'd0, 2'b00);
        expect_beat({tag, " b2"}, 32'h04, 32'h01, 16'd1, 16'd0, 2'b01);
        expect_beat({tag, " b3"}, 32'h20, 32'h11, 16'd0, 16'd1, 2'b00);
        expect_beat({tag, " b4"}, 32'h24, 32'h12, 16'd1, 16'd1, 2'b01);
        expect_beat({tag, " b5"}, 32'h40, 32'h22, 16'd0, 16'd2, 2'b00);
        expect_beat({tag, " b6"}, 32'h44, 32'h23, 16'd1, 16'd2, 2'b11);
        expect_done(tag);
    endtask

    initial begin
        rst_i = 1'b1; clear_i = 1'b0; start_i = 1'b0; ready_i = 1'b1;
        cfg_nb_iter = '0; cfg_stride = '0; cfg_base = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_i = 1'b0;
        check_eq("reset valid", 64'(valid_o), 64'd0);
        check_eq("reset busy", 64'(busy_o), 64'd0);
        check_eq("reset done", 64'(done_o), 64'd0);
        check_eq("reset offset", 64'(offset_o), 64'd0);
        check_eq("reset idx", 64'(idx_o), 64'd0);
        check_eq("reset last", 64'(last_o), 64'd0);
`ifdef MAC_LOOP_CTRL_PERF_CNT_EN
        check_eq("reset stall", 64'(stall_cnt_o), 64'd0);
`endif

        // Single loop, contiguous streams
        start_job(16'd3, 16'd0, 32'd4, 32'd8, 32'd0, 32'd0, 32'h100, 32'h200);
        check_eq("s1 busy", 64'(busy_o), 64'd1);
        expect_beat("s1 b1", 32'h100, 32'h200, 16'd0, 16'd0, 2'b00);
        expect_beat("s1 b2", 32'h104, 32'h208, 16'd1, 16'd0, 2'b00);
        expect_beat("s1 b3", 32'h108, 32'h210, 16'd2, 16'd0, 2'b00);
        expect_beat("s1 b4", 32'h10C, 32'h218, 16'd3, 16'd0, 2'b11);
        expect_done("s1");

        // Two-level jump
        start_job(16'd1, 16'd2, 32'd4, 32'd1, 32'h1C, 32'h10, 32'h0, 32'h0);
        scen2_beats("s2");

        // Backpressure: three stalled cycles on beat 2
        start_job(16'd3, 16'd0, 32'd4, 32'd8, 32'd0, 32'd0, 32'h100, 32'h200);
        expect_beat("bp b1", 32'h100, 32'h200, 16'd0, 16'd0, 2'b00);
        ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq($sformatf("bp hold%0d valid", i), 64'(valid_o), 64'd1);
            check_eq($sformatf("bp hold%0d offset", i), 64'(offset_o[0]), 64'h104);
        end
        ready_i = 1'b1;
        expect_beat("bp b2", 32'h104, 32'h208, 16'd1, 16'd0, 2'b00);
        expect_beat("bp b3", 32'h108, 32'h210, 16'd2, 16'd0, 2'b00);
        expect_beat("bp b4", 32'h10C, 32'h218, 16'd3, 16'd0, 2'b11);
        expect_done("bp");
`ifdef MAC_LOOP_CTRL_PERF_CNT_EN
        check_eq("bp stall cnt", 64'(stall_cnt_o), 64'd3);
`endif

        // Degenerate job, second job started in the done cycle
        start_job(16'd0, 16'd0, 32'd4, 32'd4, 32'd0, 32'd0, 32'h40, 32'h80);
        expect_beat("dg1 b1", 32'h40, 32'h80, 16'd0, 16'd0, 2'b11);
        check_eq("dg1 done", 64'(done_o), 64'd1);
        start_job(16'd0, 16'd0, 32'd4, 32'd4, 32'd0, 32'd0, 32'h50, 32'h90);
        expect_beat("dg2 b1", 32'h50, 32'h90, 16'd0, 16'd0, 2'b11);
        expect_done("dg2");

        // start_i and config changes during RUN are ignored
        start_job(16'd1, 16'd2, 32'd4, 32'd1, 32'h1C, 32'h10, 32'h0, 32'h0);
        expect_beat("sr b1", 32'h00, 32'h00, 16'd0, 16'd0, 2'b00);
        cfg_nb_iter = {16'd5, 16'd5};
        cfg_stride  = {32'd7, 32'd7, 32'd7, 32'd7};
        cfg_base    = {32'h999, 32'h999};
        start_i     = 1'b1;
        expect_beat("sr b2", 32'h04, 32'h01, 16'd1, 16'd0, 2'b01);
        start_i     = 1'b0;
        expect_beat("sr b3", 32'h20, 32'h11, 16'd0, 16'd1, 2'b00);
        expect_beat("sr b4", 32'h24, 32'h12, 16'd1, 16'd1, 2'b01);
        expect_beat("sr b5", 32'h40, 32'h22, 16'd0, 16'd2, 2'b00);
        expect_beat("sr b6", 32'h44, 32'h23, 16'd1, 16'd2, 2'b11);
        expect_done("sr");

        // Reset mid-job abandons it without done_o
        start_job(16'd1, 16'd2, 32'd4, 32'd1, 32'h1C, 32'h10, 32'h0, 32'h0);
        expect_beat("rs b1", 32'h00, 32'h00, 16'd0, 16'd0, 2'b00);
        expect_beat("rs b2", 32'h04, 32'h01, 16'd1, 16'd0, 2'b01);
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        check_eq("rs valid", 64'(valid_o), 64'd0);
        check_eq("rs offset", 64'(offset_o), 64'd0);
        check_eq("rs idx", 64'(idx_o), 64'd0);
        check_eq("rs done", 64'(done_o), 64'd0);
        @(negedge clk);
        check_eq("rs done later", 64'(done_o), 64'd0);
        check_eq("rs busy later", 64'(busy_o), 64'd0);

        // Offset wrap-around
        start_job(16'd1, 16'd0, 32'd8, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFC, 32'h0);
        expect_beat("wr b1", 32'hFFFF_FFFC, 32'h0, 16'd0, 16'd0, 2'b00);
        expect_beat("wr b2", 32'h0000_0004, 32'h0, 16'd1, 16'd0, 2'b11);
        expect_done("wr");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
